carfield_domain_clk_div: RTL and testbench

Per-domain clock-enable divider, one instance per Carfield domain. It takes the domain's divisor (reset value from the generated `CarfieldClkDivValue[CarfieldDomainIdx.<domain>]`) and produces a one-cycle `clk_en_o` pulse every N cycles for the domain's clock gate. Runtime divisor changes arrive over a valid/ready handshake from the control register file. A new divisor takes effect only at a period boundary, so no runt or stretched period is ever emitted.

---
 rtl/carfield_domain_clk_div.sv | 101 ++++++++++
 tb/tb_carfield_domain_clk_div.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/carfield_domain_clk_div.sv
// carfield_domain_clk_div
// Per-domain clock-enable divider. Emits a one-cycle clk_en_o pulse every
// div_q cycles for the domain clock gate. Runtime divisor updates arrive over
// a valid/ready handshake and are only applied on a period boundary (or while
// the domain is disabled), so the gate never sees a runt or stretched period.

module carfield_domain_clk_div #(
    parameter int unsigned DivWidth   = 8,
    parameter int unsigned DefaultDiv = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic                test_mode_i,
    input  logic [DivWidth-1:0] div_i,
    input  logic                div_valid_i,
    output logic                div_ready_o,
    output logic                clk_en_o,
    output logic [DivWidth-1:0] cur_div_o,
    output logic                busy_o
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] PENDING = 1'b1;

    localparam logic [DivWidth-1:0] DivOne   = DivWidth'(1);
    localparam logic [DivWidth-1:0] DivReset = DivWidth'(DefaultDiv);

    logic [0:0]          state_q;
    logic [DivWidth-1:0] div_q;
    logic [DivWidth-1:0] cnt_q;
    logic [DivWidth-1:0] pend_q;
    logic                clk_en_q;

    logic                wrap;
    logic                apply;
    logic [DivWidth-1:0] div_req;

    // Period boundary, update-apply condition and the sanitised request (0 -> 1)
    always_comb begin
        wrap    = (cnt_q == (div_q - DivOne));
        apply   = (state_q == PENDING) && (!en_i || wrap);
        div_req = (div_i == '0) ? DivOne : div_i;
    end

    // Period counter: cleared while disabled, on wrap, and when an update lands
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (!en_i || wrap || apply) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + DivOne;
        end
    end

    // Registered pulse; on the apply cycle it still reflects the old divisor
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clk_en_q <= 1'b0;
        end else begin
            clk_en_q <= en_i & wrap;
        end
    end

    // Update handshake: capture in IDLE, hold in PENDING until a boundary
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pend_q  <= '0;
            div_q   <= DivReset;
        end else begin
            case (state_q)
                IDLE: begin
                    if (div_valid_i) begin
                        pend_q  <= div_req;
                        state_q <= PENDING;
                    end
                end
                PENDING: begin
                    if (apply) begin
                        div_q   <= pend_q;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Outputs: ready/busy depend on FSM state only, test mode bypasses the gate
    always_comb begin
        div_ready_o = (state_q == IDLE);
        busy_o      = (state_q == PENDING);
        clk_en_o    = clk_en_q | test_mode_i;
        cur_div_o   = div_q;
    end

endmodule

// File: tb/tb_carfield_domain_clk_div.sv
// tb_carfield_domain_clk_div
// Directed vectors for the per-domain clock-enable divider. Each table row is
// the input set held across one rising edge and the outputs expected just
// after that edge; a hand-written sequence covers the maximum divisor.

module tb_carfield_domain_clk_div;

    localparam int unsigned DivWidth = 8;

    logic                clk_i;
    logic                rst_i;
    logic                en_i;
    logic                test_mode_i;
    logic [DivWidth-1:0] div_i;
    logic                div_valid_i;
    logic                div_ready_o;
    logic                clk_en_o;
    logic [DivWidth-1:0] cur_div_o;
    logic                busy_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic       en;
        logic       tm;
        logic [7:0] div;
        logic       valid;
        logic       exp_clk_en;
        logic       exp_ready;
        logic       exp_busy;
        logic [7:0] exp_cur;
    } vec_t;

    vec_t vecs[$];

    carfield_domain_clk_div #(
        .DivWidth  (DivWidth),
        .DefaultDiv(1)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .en_i       (en_i),
        .test_mode_i(test_mode_i),
        .div_i      (div_i),
        .div_valid_i(div_valid_i),
        .div_ready_o(div_ready_o),
        .clk_en_o   (clk_en_o),
        .cur_div_o  (cur_div_o),
        .busy_o     (busy_o)
    );

    // Free-running system clock
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic add_vec(input logic rst, input logic en, input logic tm,
                           input logic [7:0] div, input logic valid,
                           input logic ce, input logic rdy, input logic bsy,
                           input logic [7:0] cur);
        vec_t v;
        v.rst = rst; v.en = en; v.tm = tm; v.div = div; v.valid = valid;
        v.exp_clk_en = ce; v.exp_ready = rdy; v.exp_busy = bsy; v.exp_cur = cur;
        vecs.push_back(v);
    endtask

    task automatic check_output(input string name, input logic [7:0] actual,
                                input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input vec_t v, input int idx);
        @(negedge clk_i);
        rst_i       = v.rst;
        en_i        = v.en;
        test_mode_i = v.tm;
        div_i       = v.div;
        div_valid_i = v.valid;
        @(posedge clk_i);
        #1;
        check_output($sformatf("row%0d clk_en", idx), {7'd0, clk_en_o}, {7'd0, v.exp_clk_en});
        check_output($sformatf("row%0d ready", idx), {7'd0, div_ready_o}, {7'd0, v.exp_ready});
        check_output($sformatf("row%0d busy", idx), {7'd0, busy_o}, {7'd0, v.exp_busy});
        check_output($sformatf("row%0d cur_div", idx), cur_div_o, v.exp_cur);
    endtask

    // Main sequence: table of directed vectors, then the maximum-divisor case
    initial begin
        int gap;
        int first_gap;
        int second_gap;
        bit seen;

        rst_i = 1'b1; en_i = 1'b1; test_mode_i = 1'b0; div_i = '0; div_valid_i = 1'b0;

        //       rst en tm div  vld  ce rdy bsy cur
        // reset held with en high: registered pulse stays low
        add_vec(1, 1, 0, 8'd0, 0,   0, 1, 0, 8'd1);
        add_vec(1, 1, 0, 8'd0, 0,   0, 1, 0, 8'd1);
        // divisor 1: continuous enable
        add_vec(0, 1, 0, 8'd0, 0,   1, 1, 0, 8'd1);
        add_vec(0, 1, 0, 8'd0, 0,   1, 1, 0, 8'd1);
        add_vec(0, 1, 0, 8'd0, 0,   1, 1, 0, 8'd1);
        // write 4: busy one cycle, then period of 4
        add_vec(0, 1, 0, 8'd4, 1,   1, 0, 1, 8'd1);
        add_vec(0, 1, 0, 8'd0, 0,   1, 1, 0, 8'd4);
        add_vec(0, 1, 0, 8'd0, 0,   0, 1, 0, 8'd4);
        add_vec(0, 1, 0, 8'd0, 0,   0, 1, 0, 8'd4);
        add_vec(0, 1, 0, 8'd0, 0,   0, 1, 0, 8'd4);
        add_vec(0, 1, 0, 8'd0, 0,   1, 1, 0, 8'd4);
        add_vec(0, 1, 0, 8'd0, 0,   0, 1, 0, 8'd4);
        add_vec(0, 1, 0, 8'd0, 0,   0, 1, 0, 8'd4);
        add_vec(0, 1, 0, 8'd0, 0,   0, 1, 0, 8'd4);
        add_vec(0, 1, 0, 8'd0, 0,   1, 1, 0, 8'd4);
        // write 5 mid-period: waits for the 4-period boundary
        add_vec(0, 1, 0, 8'd5, 1,   0, 0, 1, 8'd4);
        add_vec(0, 1, 0, 8'd0, 0,   0, 0, 1, 8'd4);
        add_vec(0, 1, 0, 8'd0, 0,   0, 0, 1, 8'd4);
        add_vec(0, 1, 0, 8'd0, 0,   1, 1, 0, 8'd5);
        // div 5, write 2 at cnt 1: old period finishes, then period 2
        add_vec(0, 1, 0, 8'd0, 0,   0, 1, 0, 8'd5);
        add_vec(0, 1, 0, 8'd2, 1,   0, 0, 1, 8'd5);
        add_vec(0, 1, 0, 8'd0, 0,   0, 0, 1, 8'd5);
        add_vec(0, 1, 0, 8'd0, 0,   0, 0, 1, 8'd5);
        add_vec(0, 1, 0, 8'd0, 0,   1, 1, 0, 8'd2);
        add_vec(0, 1, 0, 8'd0, 0,   0, 1, 0, 8'd2);
        add_vec(0, 1, 0, 8'd0, 0,   1, 1, 0, 8'd2);
        add_vec(0, 1, 0, 8'd0, 0,   0, 1, 0, 8'd2);
        // write 0 on a wrap cycle: captured only, applied next wrap as 1
        add_vec(0, 1, 0, 8'd0, 1,   1, 0, 1, 8'd2);
        add_vec(0, 1, 0, 8'd0, 0,   0, 0, 1, 8'd2);
        add_vec(0, 1, 0, 8'd0, 0,   1, 1, 0, 8'd1);
        add_vec(0, 1, 0, 8'd0, 0,   1, 1, 0, 8'd1);
        add_vec(0, 1, 0, 8'd0, 0,   1, 1, 0, 8'd1);
        // go to 8, then request 3 and drop en at cnt 3
        add_vec(0, 1, 0, 8'd8, 1,   1, 0, 1, 8'd1);
        add_vec(0, 1, 0, 8'd0, 0,   1, 1, 0, 8'd8);
        add_vec(0, 1, 0, 8'd0, 0,   0, 1, 0, 8'd8);
        add_vec(0, 1, 0, 8'd0, 0,   0, 1, 0, 8'd8);
        add_vec(0, 1, 0, 8'd3, 1,   0, 0, 1, 8'd8);
        add_vec(0, 0, 0, 8'd0, 0,   0, 1, 0, 8'd3);
        add_vec(0, 0, 0, 8'd0, 0,   0, 1, 0, 8'd3);
        add_vec(0, 1, 0, 8'd0, 0,   0, 1, 0, 8'd3);
        add_vec(0, 1, 0, 8'd0, 0,   0, 1, 0, 8'd3);
        add_vec(0, 1, 0, 8'd0, 0,   1, 1, 0, 8'd3);
        // test mode forces the enable regardless of en
        add_vec(0, 0, 1, 8'd0, 0,   1, 1, 0, 8'd3);
        add_vec(0, 1, 1, 8'd0, 0,   1, 1, 0, 8'd3);
        add_vec(0, 1, 0, 8'd0, 0,   0, 1, 0, 8'd3);
        add_vec(0, 1, 0, 8'd0, 0,   1, 1, 0, 8'd3);
        // reach div 6, then reset while an update to 9 is pending
        add_vec(0, 1, 0, 8'd6, 1,   0, 0, 1, 8'd3);
        add_vec(0, 1, 0, 8'd0, 0,   0, 0, 1, 8'd3);
        add_vec(0, 1, 0, 8'd0, 0,   1, 1, 0, 8'd6);
        add_vec(0, 1, 0, 8'd9, 1,   0, 0, 1, 8'd6);
        add_vec(1, 1, 0, 8'd0, 0,   0, 1, 0, 8'd1);
        add_vec(0, 1, 0, 8'd0, 0,   1, 1, 0, 8'd1);
        add_vec(0, 1, 0, 8'd0, 0,   1, 1, 0, 8'd1);
        add_vec(0, 1, 0, 8'd0, 0,   1, 1, 0, 8'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i], i);
        end

        // Maximum divisor: load 255 while disabled, then measure two periods
        @(negedge clk_i);
        en_i = 1'b0; div_i = 8'd255; div_valid_i = 1'b1;
        @(posedge clk_i); #1;
        check_output("max accept busy", {7'd0, busy_o}, 8'd1);
        @(negedge clk_i);
        div_valid_i = 1'b0;
        @(posedge clk_i); #1;
        check_output("max applied cur_div", cur_div_o, 8'd255);
        @(negedge clk_i);
        en_i = 1'b1;

        gap = 0; first_gap = -1; second_gap = -1; seen = 1'b0;
        for (int c = 0; c < 600 && second_gap < 0; c++) begin
            @(posedge clk_i); #1;
            gap++;
            if (clk_en_o) begin
                if (!seen) begin
                    first_gap = gap;
                    seen = 1'b1;
                end else begin
                    second_gap = gap;
                end
                gap = 0;
            end
        end
        check_output("max first pulse", first_gap[7:0], 8'd255);
        checks++;
        if (first_gap != 255 || second_gap != 255) begin
            errors++;
            $display("[TB] FAIL max period: got %0d/%0d expected 255/255", first_gap, second_gap);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
